// File: rtl/data_mem_responder_pkg.sv
// Shared constants and types for the data memory responder.
// funct3 width codes, FSM state encoding, latency counter width.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    CLEAR
  } state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between core data port and memory responder.
// master = requester (core), slave = responder (memory).
interface data_mem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_funct3,
    output req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_funct3,
    input  req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_err
  );

endinterface

// File: rtl/data_mem_responder_lane_align.sv
// Byte-lane steering: store enables/shifted data, load extract/extend.
// Ports: write, funct3, addr_lo, wdata, raw in; be, wdata_sh, rdata, err out.
import dmem_pkg::*;

module dmem_lane_align (
  input  logic        write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] raw,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata,
  output logic        err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld;
  logic        bad;

  assign byte_sel = 8'(raw >> {addr_lo, 3'b000});
  assign half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];

  always_comb begin
    be       = 4'b0000;
    wdata_sh = '0;
    ld       = '0;
    bad      = 1'b0;
    case (funct3)
      F3_B: begin
        be       = 4'b0001 << addr_lo;
        wdata_sh = {24'b0, wdata[7:0]} << {addr_lo, 3'b000};
        ld       = {{24{byte_sel[7]}}, byte_sel};
      end
      F3_H: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_sh = {16'b0, wdata[15:0]} << {addr_lo[1], 4'b0000};
        ld       = {{16{half_sel[15]}}, half_sel};
        bad      = addr_lo[0];
      end
      F3_W: begin
        be       = 4'b1111;
        wdata_sh = wdata;
        ld       = raw;
        bad      = addr_lo != 2'b00;
      end
      F3_BU: begin
        ld  = {24'b0, byte_sel};
        bad = write;
      end
      F3_HU: begin
        ld  = {16'b0, half_sel};
        bad = write | addr_lo[0];
      end
      default: bad = 1'b1;
    endcase
  end

  assign err   = bad;
  assign rdata = (write || bad) ? '0 : ld;

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder with fixed latency, RV32I widths.
// Ports: clk, reset, bus (slave modport), busy. Option: DMEM_CLEAR_ON_RESET_EN.
import dmem_pkg::*;

module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus,
  output logic                 busy
);

  localparam int AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAT_M1 =
    CNT_W'(LATENCY - 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              enter_resp;

  logic              l_write;
  logic [2:0]        l_f3;
  logic [31:0]       l_addr, l_wdata;

  logic              a_write;
  logic [2:0]        a_f3;
  logic [31:0]       a_addr, a_wdata;

  logic [3:0]        be;
  logic [31:0]       wsh, la_rdata, raw;
  logic              la_err, rng_err, err;
  logic [AW-1:0]     idx;
  logic              commit;

  logic [31:0]       rdata_q;
  logic              err_q;

  logic [31:0]       mem [DEPTH_WORDS];

`ifdef DMEM_CLEAR_ON_RESET_EN
  logic [AW-1:0]     clr_idx;
`endif

  // With LATENCY=1 the accept edge is also the edge entering RESP,
  // so the access uses the live bus fields instead of the latches.
  assign a_write = (state == IDLE) ? bus.req_write  : l_write;
  assign a_f3    = (state == IDLE) ? bus.req_funct3 : l_f3;
  assign a_addr  = (state == IDLE) ? bus.req_addr   : l_addr;
  assign a_wdata = (state == IDLE) ? bus.req_wdata  : l_wdata;

  assign rng_err = a_addr[31:2] >= 30'(DEPTH_WORDS);
  assign idx     = a_addr[AW+1:2];
  assign raw     = mem[idx];
  assign err     = la_err | rng_err;
  assign commit  = enter_resp & a_write & ~err & ~reset;

  dmem_lane_align u_align (
    .write    (a_write),
    .funct3   (a_f3),
    .addr_lo  (a_addr[1:0]),
    .wdata    (a_wdata),
    .raw      (raw),
    .be       (be),
    .wdata_sh (wsh),
    .rdata    (la_rdata),
    .err      (la_err)
  );

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          cnt_n = LAT_M1;
          if (LATENCY == 1) begin
            state_n    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_n    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_n = IDLE;
      end
`ifdef DMEM_CLEAR_ON_RESET_EN
      CLEAR: begin
        if (clr_idx == AW'(DEPTH_WORDS - 1))
          state_n = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
      state <= CLEAR;
`else
      state <= IDLE;
`endif
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

`ifdef DMEM_CLEAR_ON_RESET_EN
  always_ff @(posedge clk) begin
    if (reset)
      clr_idx <= '0;
    else if (state == CLEAR)
      clr_idx <= clr_idx + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (state == IDLE && bus.req_valid) begin
      l_write <= bus.req_write;
      l_f3    <= bus.req_funct3;
      l_addr  <= bus.req_addr;
      l_wdata <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (enter_resp) begin
      err_q   <= err;
      rdata_q <= rng_err ? '0 : la_rdata;
    end
  end

  always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
    if (state == CLEAR)
      mem[clr_idx] <= '0;
    else
`endif
    if (commit) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wsh[8*i +: 8];
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign busy          = (state != IDLE);

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder (memory-side) end of the core's data load/store interface.
- Accepts one request at a time over a valid/ready handshake, models a fixed access latency, and returns load data or write completion over a second valid/ready channel.
- Load/store width is decoded from RV32I funct3. Sits behind the core's data port as a drop-in multi-cycle replacement for the combinational data memory, enabling stall-capable core revisions.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; address range is 0 to 4*DEPTH_WORDS-1.
- LATENCY, 2, cycles from request accept edge to rsp_valid high; legal range 1..15.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept request
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (the byte or halfword occupies the low bits)
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester accepts response
- rsp_rdata  out  32  load result, already extended; 0 for stores and errors
- rsp_err  out  1  request was rejected (misaligned, out of range, or illegal funct3)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset:
  - Synchronous, active-high; takes effect on the clock edge and overrides everything else.
  - Clock and reset are named clk and reset; reset is synchronous and active-high.
  - State goes to IDLE. rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0. req_ready=1 in the cycle after reset deasserts.
  - Memory contents are preserved across reset unless DMEM_CLEAR_ON_RESET_EN is defined.
- FSM states:
  - IDLE: req_ready=1. Handshake is req_valid && req_ready on a clock edge. On handshake, latch write, funct3, addr, wdata; load the latency counter with LATENCY-1; go to WAIT, or directly to RESP if LATENCY=1.
  - WAIT: req_ready=0. Counter decrements each cycle; at 0, go to RESP.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err are stable until the handshake. On rsp_valid && rsp_ready, go to IDLE.
- Latency:
  - Response is registered; rsp_valid rises exactly LATENCY edges after the accept edge.
  - rsp_ready held low stalls in RESP indefinitely with outputs unchanged.
  - Minimum throughput is one request per LATENCY+2 cycles, since there is one IDLE cycle after each response.
- Memory update timing:
  - Stores write the memory on the edge entering RESP, never earlier.
  - Loads sample the memory on the same edge, so a load after a store returns the new data.
- Error detection (rsp_err=1, no write, rsp_rdata=0):
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - addr[31:2] >= DEPTH_WORDS.
  - Load funct3 in {011, 110, 111}.
  - Store funct3 not in {000, 001, 010}.
- Loads:
  - 000 LB: sign-extended byte, selected by addr[1:0].
  - 001 LH: sign-extended halfword, selected by addr[1].
  - 010 LW: full word.
  - 100 LBU: zero-extended byte.
  - 101 LHU: zero-extended halfword.
- Stores:
  - SB writes one byte lane, SH writes two lanes, SW writes all four.
  - Unselected lanes are unchanged.
  - rsp_rdata=0 on the store response.
- Reset mid-operation: a request latched in WAIT is discarded and its pending store never commits. A response in RESP is dropped.
- Inputs while busy: req_valid asserted outside IDLE is ignored; the requester must hold it, per the valid/ready rule.

Optional Feature:
- Macro: DMEM_CLEAR_ON_RESET_EN.
- Defined:
  - Reset enters state CLEAR, which writes zero to one word per cycle from index 0 to DEPTH_WORDS-1, then goes to IDLE.
  - During CLEAR: req_ready=0 and busy=1.
  - Reset asserted again during CLEAR restarts the clear at index 0.
- Undefined: no CLEAR state; memory is left uninitialised at power-up and untouched by reset.

Decomposition:
- Package dmem_pkg:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state typedef: IDLE, WAIT, RESP, CLEAR.
  - Latency counter width constant: 4 bits.
- Sub-module dmem_lane_align (combinational):
  - Store path: produces the 4-bit byte enable and lane-shifted write data from funct3, addr[1:0] and wdata.
  - Load path: extracts and extends rsp_rdata from the raw word.
  - Also produces the misalign/illegal-funct3 flag.
  - The top holds the FSM, the counter, and the memory array.

Test Plan:
- LATENCY=2: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> store response rsp_err=0, rdata=0; load rsp_valid exactly 2 edges after accept, rdata=0xDEADBEEF.
- After the above: SB addr 0x13 data 0x80, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80ADBEEF.
- SH addr 0x11 -> rsp_err=1, memory unchanged; LW addr 0x400 with DEPTH_WORDS=256 -> rsp_err=1, rdata=0; load funct3=011 -> rsp_err=1.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata and err stable throughout, req_ready=0; release -> IDLE next cycle, req_ready=1.
- Accept SW 0x20 data 0x12345678, assert reset in WAIT -> no response; subsequent LW 0x20 returns the prior contents.
- DMEM_CLEAR_ON_RESET_EN defined: reset -> busy=1 for DEPTH_WORDS cycles, then LW to any address returns 0.
